// File: rtl/acc_mat_loader.sv
// acc_mat_loader: collects two N x N operand matrices from a valid/ready
// element stream (A first, then B, row-major). It then launches the
// multiplier with a one-cycle start pulse and holds off new input until the
// multiplier reports done.
module acc_mat_loader #(
   parameter int mat_size = 2,
   parameter int dat_size = 8
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [dat_size-1:0]                               in_data,
   input  logic                                              in_valid,
   output logic                                              in_ready,
   output logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]   mat_A,
   output logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]   mat_B,
   output logic                                              start,
   input  logic                                              done,
   output logic                                              busy,
   output logic                                              job_done
);

   localparam int               IDX_W = (mat_size > 1) ? $clog2(mat_size) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(mat_size - 1);

   typedef enum logic [1:0] {
      LOAD_A    = 2'd0,
      LOAD_B    = 2'd1,
      START     = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;
   logic             job_done_q, job_done_d;

   logic [mat_size-1:0][mat_size-1:0][dat_size-1:0] mat_a_q;
   logic [mat_size-1:0][mat_size-1:0][dat_size-1:0] mat_b_q;

   logic xfer;
   logic last_elem;
   logic wr_a;
   logic wr_b;

   // in_ready_q is high only in the load states, so a transfer can only
   // happen while one of the matrices is being filled.
   assign xfer      = in_valid && in_ready_q;
   assign last_elem = (row_q == LAST) && (col_q == LAST);
   assign wr_a      = xfer && (state_q == LOAD_A);
   assign wr_b      = xfer && (state_q == LOAD_B);

   // Next-state logic: element counters, FSM transitions and output decode.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;

      // Counters advance per accepted element. Both wrap to zero on the
      // last element, which leaves them cleared for the next matrix.
      if (xfer) begin
         if (col_q == LAST) begin
            col_d = '0;
            row_d = (row_q == LAST) ? '0 : row_q + IDX_W'(1);
         end else begin
            col_d = col_q + IDX_W'(1);
         end
      end

      case (state_q)
         LOAD_A:    if (xfer && last_elem) state_d = LOAD_B;
         LOAD_B:    if (xfer && last_elem) state_d = START;
         START:     state_d = WAIT_DONE;
         WAIT_DONE: if (done) state_d = LOAD_A;
         default:   state_d = LOAD_A;
      endcase

      // Outputs are registered copies of the decode of the next state, so
      // each one matches the current state's decode in every cycle.
      start_d    = (state_d == START);
      busy_d     = (state_d == START) || (state_d == WAIT_DONE);
      in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
      job_done_d = (state_q == WAIT_DONE) && done;
   end

   // FSM, counter and control-output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD_A;
         row_q      <= '0;
         col_q      <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
         job_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
         job_done_q <= job_done_d;
      end
   end

   // Operand storage. Elements are written only on accepted transfers, so
   // both matrices stay frozen from START until the next job's first element.
   always_ff @(posedge clk) begin
      if (rst) begin
         mat_a_q <= '0;
         mat_b_q <= '0;
      end else begin
         if (wr_a) mat_a_q[row_q][col_q] <= in_data;
         if (wr_b) mat_b_q[row_q][col_q] <= in_data;
      end
   end

   assign mat_A    = mat_a_q;
   assign mat_B    = mat_b_q;
   assign start    = start_q;
   assign busy     = busy_q;
   assign in_ready = in_ready_q;
   assign job_done = job_done_q;

endmodule

// File: tb/tb_acc_mat_loader.sv
// Self-checking bench for acc_mat_loader (N=2, 8-bit elements).
// Expected operand matrices are queued when a stream is driven and popped
// when the loader raises start.
module tb_acc_mat_loader;

   typedef logic [1:0][1:0][7:0] mat_t;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   mat_t       mat_A;
   mat_t       mat_B;
   logic       start;
   logic       done;
   logic       busy;
   logic       job_done;

   int   n_cmp;
   int   n_err;
   int   start_cnt;
   int   jd_cnt;
   int   s0;
   int   j0;
   mat_t exp_a[$];
   mat_t exp_b[$];
   mat_t ea;
   mat_t eb;
   mat_t last_a;
   mat_t last_b;

   acc_mat_loader #(.mat_size(2), .dat_size(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mat_A    (mat_A),
      .mat_B    (mat_B),
      .start    (start),
      .done     (done),
      .busy     (busy),
      .job_done (job_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (start === 1'b1)    start_cnt++;
         if (job_done === 1'b1) jd_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Streams base..base+7 (A then B); optional two idle cycles between
   // elements. Afterwards in_valid is left at 'hold' with data 99.
   task automatic stream(input logic [7:0] base, input bit gaps, input bit hold);
      mat_t a;
      mat_t b;
      for (int i = 0; i < 4; i++) begin
         a[i/2][i%2] = base + 8'(i);
         b[i/2][i%2] = base + 8'(i + 4);
      end
      exp_a.push_back(a);
      exp_b.push_back(b);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(i);
         step();
         if (gaps && i < 7) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            step();
            step();
         end
      end
      in_valid = hold;
      in_data  = 8'd99;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sample();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (job_done !== 1'b0) begin n_err++; $display("FAIL reset_job_done: got %b want 0", job_done); end
      n_cmp++; if (mat_A !== '0 || mat_B !== '0) begin n_err++; $display("FAIL reset_mats: got A=%h B=%h want 0", mat_A, mat_B); end
   endtask

   task automatic test_load_basic();
      step();
      s0 = start_cnt;
      stream(8'd1, 1'b0, 1'b1);
      sample();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      last_a = ea;
      last_b = eb;
      n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL load_start: got %b want 1", start); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy_with_start: got %b want 1", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_in_start: got %b want 0", in_ready); end
      n_cmp++; if (mat_A !== ea) begin n_err++; $display("FAIL load_mat_A: got %h want %h", mat_A, ea); end
      n_cmp++; if (mat_B !== eb) begin n_err++; $display("FAIL load_mat_B: got %h want %h", mat_B, eb); end
      step();
      sample();
      n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL load_start_one_cycle: got %b want 0", start); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy_wait: got %b want 1", busy); end
      n_cmp++; if (mat_A !== last_a || mat_B !== last_b) begin n_err++; $display("FAIL load_mats_in_start: got A=%h B=%h want A=%h B=%h", mat_A, mat_B, last_a, last_b); end
   endtask

   // Entered in WAIT_DONE with in_valid=1, in_data=99 still driven.
   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) begin
         step();
         sample();
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
         n_cmp++; if (mat_A !== last_a || mat_B !== last_b) begin n_err++; $display("FAIL bp_mats: got A=%h B=%h want A=%h B=%h", mat_A, mat_B, last_a, last_b); end
      end
      step();
      done     = 1'b1;
      in_valid = 1'b0;
      step();
      done = 1'b0;
      sample();
      n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL bp_job_done: got %b want 1", job_done); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_with_job_done: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_after_done: got %b want 0", busy); end
      step();
      sample();
      n_cmp++; if (job_done !== 1'b0) begin n_err++; $display("FAIL bp_job_done_one_cycle: got %b want 0", job_done); end
      n_cmp++; if (mat_A !== last_a || mat_B !== last_b) begin n_err++; $display("FAIL bp_mats_after_done: got A=%h B=%h want A=%h B=%h", mat_A, mat_B, last_a, last_b); end
      n_cmp++; if (start_cnt !== s0 + 1) begin n_err++; $display("FAIL bp_start_count: got %0d want %0d", start_cnt, s0 + 1); end
   endtask

   task automatic test_gaps();
      step();
      stream(8'd1, 1'b1, 1'b0);
      sample();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL gaps_start: got %b want 1", start); end
      n_cmp++; if (mat_A !== ea) begin n_err++; $display("FAIL gaps_mat_A: got %h want %h", mat_A, ea); end
      n_cmp++; if (mat_B !== eb) begin n_err++; $display("FAIL gaps_mat_B: got %h want %h", mat_B, eb); end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      sample();
      n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL gaps_job_done: got %b want 1", job_done); end
   endtask

   task automatic test_reset_midload();
      step();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'd40 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      sample();
      n_cmp++; if (mat_A !== '0 || mat_B !== '0) begin n_err++; $display("FAIL rstmid_mats: got A=%h B=%h want 0", mat_A, mat_B); end
      n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl: got ready=%b busy=%b start=%b want 1 0 0", in_ready, busy, start); end
      step();
      stream(8'd20, 1'b0, 1'b0);
      sample();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL rstmid_start: got %b want 1", start); end
      n_cmp++; if (mat_A !== ea) begin n_err++; $display("FAIL rstmid_mat_A: got %h want %h", mat_A, ea); end
      n_cmp++; if (mat_B !== eb) begin n_err++; $display("FAIL rstmid_mat_B: got %h want %h", mat_B, eb); end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      sample();
   endtask

   task automatic test_spurious_done();
      step();
      j0   = jd_cnt;
      done = 1'b1;
      stream(8'd30, 1'b0, 1'b0);
      sample();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL spur_start: got %b want 1", start); end
      n_cmp++; if (job_done !== 1'b0 || jd_cnt !== j0) begin n_err++; $display("FAIL spur_no_job_done: got job_done=%b count=%0d want 0 %0d", job_done, jd_cnt, j0); end
      n_cmp++; if (mat_A !== ea) begin n_err++; $display("FAIL spur_mat_A: got %h want %h", mat_A, ea); end
      n_cmp++; if (mat_B !== eb) begin n_err++; $display("FAIL spur_mat_B: got %h want %h", mat_B, eb); end
      step();
      sample();
      n_cmp++; if (job_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL spur_wait: got job_done=%b busy=%b want 0 1", job_done, busy); end
      step();
      done = 1'b0;
      sample();
      n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL spur_job_done_after_start: got %b want 1", job_done); end
      step();
      n_cmp++; if (jd_cnt !== j0 + 1) begin n_err++; $display("FAIL spur_job_done_count: got %0d want %0d", jd_cnt, j0 + 1); end
   endtask

   task automatic test_back_to_back();
      step();
      s0 = start_cnt;
      j0 = jd_cnt;
      stream(8'd1, 1'b0, 1'b0);
      sample();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_cmp++; if (start !== 1'b1 || mat_A !== ea || mat_B !== eb) begin n_err++; $display("FAIL b2b_job1: got start=%b A=%h B=%h want 1 %h %h", start, mat_A, mat_B, ea, eb); end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      stream(8'd10, 1'b0, 1'b0);
      sample();
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL b2b_start2: got %b want 1", start); end
      n_cmp++; if (mat_A !== ea) begin n_err++; $display("FAIL b2b_mat_A: got %h want %h", mat_A, ea); end
      n_cmp++; if (mat_B !== eb) begin n_err++; $display("FAIL b2b_mat_B: got %h want %h", mat_B, eb); end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      step();
      n_cmp++; if (start_cnt !== s0 + 2) begin n_err++; $display("FAIL b2b_start_count: got %0d want %0d", start_cnt, s0 + 2); end
      n_cmp++; if (jd_cnt !== j0 + 2) begin n_err++; $display("FAIL b2b_job_done_count: got %0d want %0d", jd_cnt, j0 + 2); end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      start_cnt = 0;
      jd_cnt    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      done      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_load_basic();
      test_backpressure();
      test_gaps();
      test_reset_midload();
      test_spurious_done();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/acc_mat_loader.md
# acc_mat_loader

Upstream feeder for the accelerator's matrix-multiply stage. It accepts matrix elements one per transfer over a valid/ready stream, in row-major order: all of A first, then all of B. It holds both operand matrices in registers, then issues a one-cycle `start` pulse to the multiplier and waits for its `done`. It accepts no new elements until that job completes.

## Interface
- `mat_size`, default 2: matrix dimension N; each operand has N×N elements.
- `dat_size`, default 8: element width in bits.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  dat_size: element value.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: loader accepts the element this cycle.
- `mat_A`  out  [dat_size-1:0] × [mat_size][mat_size]: operand A, registered, indexed [row][col].
- `mat_B`  out  [dat_size-1:0] × [mat_size][mat_size]: operand B, registered, indexed [row][col].
- `start`  out  1: one-cycle pulse launching the multiplier.
- `done`  in  1: multiplier completion, sampled as a level.
- `busy`  out  1: high while a job is launched or in flight.
- `job_done`  out  1: one-cycle pulse when the multiplier's `done` has been observed.

## Operation
- A transfer happens on a rising edge where `in_valid && in_ready`.
- Counters:
  - `row` and `col` each range 0..N-1.
  - `col` increments on every transfer.
  - When `col` wraps from N-1 to 0, `row` increments.
  - When `row` wraps, the FSM changes state.
- FSM states: LOAD_A, LOAD_B, START, WAIT_DONE.
  - LOAD_A: `in_ready`=1. Each transfer writes `mat_A[row][col]`. The transfer at row=col=N-1 moves the FSM to LOAD_B and zeroes the counters.
  - LOAD_B: `in_ready`=1. Each transfer writes `mat_B[row][col]`. The transfer at row=col=N-1 moves the FSM to START.
  - START: `start`=1 and `in_ready`=0. The FSM moves to WAIT_DONE unconditionally after one cycle.
  - WAIT_DONE: `in_ready`=0 and `start`=0. When `done`=1, the FSM moves to LOAD_A and `job_done` is registered high for the following cycle.
- Output decoding:
  - `busy` = (state == START || state == WAIT_DONE), decoded from state.
  - `in_ready` is decoded from state only; it does not depend on `in_valid`.
- `mat_A` and `mat_B` change only on accepted transfers. They are therefore stable from START until the next job's first transfer. They are not cleared between jobs; each job overwrites every element.
- Elements are stored unmodified, with no width conversion. There is no arithmetic other than the counters.
- `done` is ignored in LOAD_A, LOAD_B and START.
- Contract with the multiplier: it must deassert `done` within one cycle of `start`. The loader does not edge-detect `done`.
- `in_valid` is ignored while `in_ready`=0, and `in_data` is not captured then.

## Timing
- Reset values:
  - state = LOAD_A, row = col = 0.
  - All `mat_A` and `mat_B` elements = 0.
  - `start` = 0, `job_done` = 0, `busy` = 0, `in_ready` = 1 (the cycle after reset).
- `rst` asserted in any state, including mid-load and WAIT_DONE, returns the block to the reset values on that edge. Partially loaded data is discarded.
- Throughput: one element per cycle with `in_valid` held high. A full load takes 2·N² cycles.
- Latency:
  - Last B transfer at edge k: `start`=1 during cycle k+1, WAIT_DONE from cycle k+2.
  - `done` sampled high at edge m: `job_done`=1 and `in_ready`=1 during cycle m+1.
- Minimum job turnaround is 2·N² + 2 cycles plus the multiplier's latency.
- Gaps in `in_valid` stall the counters without losing position.

## Test plan
- Load, N=2, `in_valid` high every cycle:
  - Stream 1,2,3,4,5,6,7,8.
  - Required: `mat_A` = {{1,2},{3,4}}, `mat_B` = {{5,6},{7,8}}.
  - `start` high exactly one cycle, one cycle after the 8th transfer.
  - `busy` rises with `start`.
- Backpressure:
  - Hold `in_valid`=1 with `in_data`=99 during START and WAIT_DONE.
  - Required: `in_ready`=0 and no matrix element changes.
  - Raise `done` 5 cycles later. Required: `job_done` pulses one cycle, and `in_ready`=1 on the same cycle.
- Stream gaps: toggle `in_valid` 1,0,0,1,… over the same 8 values. Required: identical matrices to the first scenario, with `start` after the 8th accepted transfer.
- Reset mid-load:
  - Assert `rst` after 5 transfers.
  - Required: all matrices 0, state LOAD_A.
  - A fresh stream of 8 values is then loaded correctly into A then B.
- Spurious `done`:
  - Hold `done`=1 during LOAD_A and LOAD_B.
  - Required: no `job_done` pulse and loading unaffected.
  - `job_done` pulses only after START.
- Back-to-back jobs:
  - Run two jobs; the second streams 10..17.
  - Required: the second `start` shows `mat_A` = {{10,11},{12,13}} and `mat_B` = {{14,15},{16,17}}.
  - Exactly two `start` pulses and two `job_done` pulses.
